// File: rtl/letter_scan_scheduler_pkg.sv
// Shared definitions for the letter scan scheduler: FSM state encoding,
// column width of the recognizer interface and modulo index helper.
package letter_scan_scheduler_pkg;

    localparam int COL_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    // (a + b) mod n for operands already below n; works for any n, not just powers of two
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/letter_scan_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr, wrapping from NCH-1 back to 0.
module rr_arbiter
    import letter_scan_scheduler_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [CH_W-1:0] gnt_idx
);

    logic            w_found;
    logic [CH_W-1:0] w_cand;

    // Scan candidates in priority order starting at ptr; first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_cand = CH_W'(wrap_add(int'(ptr), k, NCH));
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt_idx      = w_cand;
                gnt[w_cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/letter_scan_scheduler.sv
// Shares one letter-recognizer engine among NCH column sources. A source is
// granted round-robin for a whole COLS-column frame, its columns are streamed
// to the engine, the match is sampled RD_LAT cycles after the last column and
// returned as {channel, match, abort} on a valid/ready result port.
module letter_scan_scheduler
    import letter_scan_scheduler_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int COLS   = 3,
    parameter  int RD_LAT = 1,
    localparam int CH_W   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 restart,
    input  logic [NCH-1:0]       req_valid,
    input  logic [COL_W*NCH-1:0] req_bits,
    output logic [NCH-1:0]       req_ready,
    output logic [COL_W-1:0]     rd_bits,
    output logic                 rd_restart,
    input  logic                 rd_match,
    output logic                 res_valid,
    output logic [CH_W-1:0]      res_chan,
    output logic                 res_match,
    output logic                 res_abort,
    input  logic                 res_ready
);

    localparam int BEAT_W = $clog2(COLS + 1);
    localparam int WCNT_W = $clog2(RD_LAT + 1);

    state_t              r_state, w_state_nxt;
    logic [CH_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [CH_W-1:0]     r_grant, w_grant_nxt;
    logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
    logic                r_res_match, w_res_match_nxt;
    logic                r_res_abort, w_res_abort_nxt;

    logic [NCH-1:0]      w_arb_gnt;
    logic [CH_W-1:0]     w_arb_idx;
    logic [NCH-1:0]      w_gnt_onehot;
    logic                w_gnt_valid;
    logic [COL_W-1:0]    w_cols [NCH];

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_cols
        assign w_cols[g] = req_bits[g*COL_W +: COL_W];
    end

    assign w_gnt_onehot = NCH'(1) << r_grant;
    assign w_gnt_valid  = req_valid[r_grant];

    // State, counters and result latch; reset returns everything to the cleared frame
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_beat      <= '0;
            r_wcnt      <= '0;
            r_res_match <= 1'b0;
            r_res_abort <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_beat      <= w_beat_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_res_match <= w_res_match_nxt;
            r_res_abort <= w_res_abort_nxt;
        end
    end

    // Next-state logic and all port outputs; engine held cleared outside STREAM/WAIT
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_nxt     = r_grant;
        w_beat_nxt      = r_beat;
        w_wcnt_nxt      = r_wcnt;
        w_res_match_nxt = r_res_match;
        w_res_abort_nxt = r_res_abort;
        req_ready       = '0;
        rd_bits         = '0;
        rd_restart      = 1'b1;
        res_valid       = 1'b0;
        res_chan        = '0;
        res_match       = 1'b0;
        res_abort       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|w_arb_gnt) begin
                    w_grant_nxt = w_arb_idx;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_STREAM;
                end
            end

            S_STREAM: begin
                rd_restart = 1'b0;
                if (w_gnt_valid) begin
                    rd_bits   = w_cols[r_grant];
                    req_ready = w_gnt_onehot;
                    if (r_beat == BEAT_W'(COLS - 1)) begin
                        w_wcnt_nxt  = WCNT_W'(1);
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end else begin
                    // A missing beat breaks the frame: report it as aborted
                    w_res_match_nxt = 1'b0;
                    w_res_abort_nxt = 1'b1;
                    w_state_nxt     = S_REPORT;
                end
            end

            S_WAIT: begin
                rd_restart = 1'b0;
                if (r_wcnt == WCNT_W'(RD_LAT)) begin
                    w_res_match_nxt = rd_match;
                    w_res_abort_nxt = 1'b0;
                    w_state_nxt     = S_REPORT;
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end

            S_REPORT: begin
                res_valid = 1'b1;
                res_chan  = r_grant;
                res_match = r_res_match;
                res_abort = r_res_abort;
                if (res_ready) begin
                    w_rr_ptr_nxt = CH_W'(wrap_add(int'(r_grant), 1, NCH));
                    w_state_nxt  = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
